// File: rtl/mole_judge.sv
// mole_judge -- Whac-A-Mole game core.
//   Takes one-cycle press pulses from the per-hole debouncers and picks mole
//   holes with a free-running 16-bit Galois LFSR. Each mole is visible for a
//   fixed window, then judged as a hit or a miss. Keeps a saturating 4-digit
//   BCD score and a binary miss count, and ends the game after MAX_MISSES.
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active HIGH (the name is historical)
//   start      one-cycle start pulse (honoured in IDLE and OVER only)
//   press      one-cycle press pulses, bit i = hole i (judged in UP only)
//   mole       one-hot lit hole, zero when no mole is shown
//   score_bcd  BCD hit count, holds at 16'h9999
//   misses     binary miss count
//   hit_pulse  one cycle per hit
//   miss_pulse one cycle per miss (wrong hole or timeout)
//   playing    high in GAP or UP
//   game_over  high in OVER
// All outputs are registered.
module mole_judge #(
    parameter int          N_HOLES    = 8,
    parameter int          UP_CYCLES  = 25_000_000,
    parameter int          GAP_CYCLES = 12_500_000,
    parameter int          MAX_MISSES = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_HOLES-1:0] press,
    output logic [N_HOLES-1:0] mole,
    output logic [15:0]        score_bcd,
    output logic [3:0]         misses,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               playing,
    output logic               game_over
);
    localparam int IDXW = $clog2(N_HOLES);
    localparam int TMAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] UP_LOAD  = TW'(UP_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
    localparam logic [3:0]    MAXM     = 4'(MAX_MISSES);

    typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [15:0]     lfsr, lfsr_nxt;
    // Hole of the current mole; it also serves as the "previous hole" when
    // the next one is picked, since it is only rewritten on entry to UP.
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] cand, pick;
    logic [15:0]     score_inc;
    logic            carry;
    logic [3:0]      misses_inc;

    assign lfsr_nxt   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign misses_inc = misses + 4'd1;

    // Fold the raw LFSR bits into range, then step past the previous hole so
    // the same hole never lights twice in a row.
    always_comb begin
        cand = lfsr[IDXW-1:0];
        if (int'(cand) >= N_HOLES)
            cand = cand - IDXW'(N_HOLES);
        pick = cand;
        if (cand == idx)
            pick = (int'(cand) == N_HOLES - 1) ? '0 : cand + IDXW'(1);
    end

    // BCD +1 with ripple carry across digits; 9999 holds.
    always_comb begin
        score_inc = score_bcd;
        carry     = 1'b1;
        if (score_bcd != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (score_bcd[4*d +: 4] == 4'd9) begin
                        score_inc[4*d +: 4] = 4'd0;
                    end else begin
                        score_inc[4*d +: 4] = score_bcd[4*d +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            lfsr       <= LFSR_SEED;
            idx        <= '0;
            mole       <= '0;
            score_bcd  <= '0;
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            playing    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            lfsr       <= lfsr_nxt;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state     <= GAP;
                        timer     <= GAP_LOAD;
                        score_bcd <= '0;
                        misses    <= '0;
                        playing   <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        state <= UP;
                        idx   <= pick;
                        mole  <= N_HOLES'(1) << pick;
                        timer <= UP_LOAD;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                UP: begin
                    // Any press is judged before a coincident timeout.
                    if ((|press) || timer == '0) begin
                        mole  <= '0;
                        timer <= GAP_LOAD;
                        if (press[idx]) begin
                            hit_pulse <= 1'b1;
                            score_bcd <= score_inc;
                            state     <= GAP;
                        end else begin
                            miss_pulse <= 1'b1;
                            misses     <= misses_inc;
                            if (misses_inc == MAXM) begin
                                state     <= OVER;
                                playing   <= 1'b0;
                                game_over <= 1'b1;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
